digit_serial_addsub: RTL and testbench



---
 rtl/digit_serial_addsub_pkg.sv | 16 +
 rtl/digit_serial_addsub_digit_adder.sv | 29 ++
 rtl/digit_serial_addsub.sv | 118 +++++++++++
 tb/tb_digit_serial_addsub.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/digit_serial_addsub_pkg.sv
// Shared definitions for multi-cycle arithmetic units: the handshake FSM
// state encoding and the bit ordering of the {ovf, zero, cout} flag vector.
package digit_serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FLAG_COUT = 0;
    localparam int FLAG_ZERO = 1;
    localparam int FLAG_OVF  = 2;
    localparam int FLAG_W    = 3;

endpackage

// File: rtl/digit_serial_addsub_digit_adder.sv
// DIGIT-bit ripple-carry stage built from full-adder cells. Besides the
// carry out it exports the carry into the top bit so the caller can form
// the signed-overflow flag on the most significant digit.
module digit_adder
    import digit_serial_addsub_pkg::*;
#(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] sum,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign sum[i]  = x[i] ^ y[i] ^ c[i];
        assign c[i+1]  = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co    = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: a WIDTH-bit operation is processed DIGIT
// bits per clock, least significant digit first, by one reused ripple stage.
// Subtraction is done as a + ~b + ~cin, so it yields a - b - cin.
module digit_serial_addsub
    import digit_serial_addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NDIG - 1);

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  opa;
    logic [WIDTH-1:0]  opb;
    logic [WIDTH-1:0]  acc;
    logic [WIDTH-1:0]  acc_next;
    logic [WIDTH-1:0]  s_q;
    logic              carry;
    logic [IDXW-1:0]   idx;
    logic [DIGIT-1:0]  dsum;
    logic              dco;
    logic              dmsb;
    logic [FLAG_W-1:0] flags;
    logic              launch;
    logic              last;

    assign launch = start && ((state == IDLE) || (state == DONE));
    assign last   = (state == RUN) && (idx == LAST);

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .x     (opa[idx*DIGIT +: DIGIT]),
        .y     (opb[idx*DIGIT +: DIGIT]),
        .ci    (carry),
        .sum   (dsum),
        .co    (dco),
        .c_msb (dmsb)
    );

    // State register; reset returns to IDLE and so aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: launch from IDLE or DONE, leave RUN after the last digit.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (idx == LAST) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Partial result with the digit being computed this cycle merged in.
    always_comb begin
        acc_next = acc;
        acc_next[idx*DIGIT +: DIGIT] = dsum;
    end

    // Operand capture, digit stepping, and result/flag update on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            acc   <= '0;
            s_q   <= '0;
            flags <= '0;
        end else if (launch) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub ? ~cin : cin;
            idx   <= '0;
        end else if (state == RUN) begin
            acc   <= acc_next;
            carry <= dco;
            idx   <= idx + 1'b1;
            if (last) begin
                s_q              <= acc_next;
                flags[FLAG_COUT] <= dco;
                flags[FLAG_OVF]  <= dmsb ^ dco;
                flags[FLAG_ZERO] <= (acc_next == '0);
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign s    = s_q;
    assign cout = flags[FLAG_COUT];
    assign ovf  = flags[FLAG_OVF];
    assign zero = flags[FLAG_ZERO];

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Directed bench for the digit-serial adder/subtractor. The main instance
// uses DIGIT=8; DIGIT=32 and DIGIT=1 instances share the inputs and are
// checked against a reference model in the final sweep.
module tb_digit_serial_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sub;
    logic        cin;
    logic [31:0] a;
    logic [31:0] b;

    logic        busy, done, cout, ovf, zero;
    logic [31:0] s;
    logic        busy32, done32, cout32, ovf32, zero32;
    logic [31:0] s32;
    logic        busy1, done1, cout1, ovf1, zero1;
    logic [31:0] s1;

    int total = 0;
    int bad   = 0;

    digit_serial_addsub #(.WIDTH(32), .DIGIT(8)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf), .zero(zero)
    );

    digit_serial_addsub #(.WIDTH(32), .DIGIT(32)) dut32 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy32), .done(done32), .s(s32), .cout(cout32), .ovf(ovf32), .zero(zero32)
    );

    digit_serial_addsub #(.WIDTH(32), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1), .zero(zero1)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the start edge.
    task automatic applyStimulus(input logic su, input logic [31:0] av, input logic [31:0] bv,
                                 input logic ci);
        start = 1'b1;
        sub   = su;
        a     = av;
        b     = bv;
        cin   = ci;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic expectRun(input string tag);
        for (int i = 0; i < 4; i++) begin
            checkOutput({tag, " busy"}, {31'd0, busy}, 32'd1);
            checkOutput({tag, " done early"}, {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        checkOutput({tag, " done"}, {31'd0, done}, 32'd1);
        checkOutput({tag, " busy end"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic expectResult(input string tag, input logic [31:0] es, input logic ec,
                                input logic eo, input logic ez);
        checkOutput({tag, " s"}, s, es);
        checkOutput({tag, " cout"}, {31'd0, cout}, {31'd0, ec});
        checkOutput({tag, " ovf"}, {31'd0, ovf}, {31'd0, eo});
        checkOutput({tag, " zero"}, {31'd0, zero}, {31'd0, ez});
    endtask

    task automatic runOp(input string tag, input logic su, input logic [31:0] av,
                         input logic [31:0] bv, input logic ci, input logic [31:0] es,
                         input logic ec, input logic eo, input logic ez);
        applyStimulus(su, av, bv, ci);
        expectRun(tag);
        expectResult(tag, es, ec, eo, ez);
        @(negedge clk);
        checkOutput({tag, " idle done"}, {31'd0, done}, 32'd0);
        checkOutput({tag, " idle busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic refModel(input logic su, input logic [31:0] av, input logic [31:0] bv,
                            input logic ci, output logic [31:0] rs, output logic rc,
                            output logic ro, output logic rz);
        logic [31:0] bb;
        logic [32:0] full;
        bb   = su ? ~bv : bv;
        full = {1'b0, av} + {1'b0, bb} + {32'd0, su ? ~ci : ci};
        rs   = full[31:0];
        rc   = full[32];
        ro   = (av[31] == bb[31]) && (rs[31] != av[31]);
        rz   = (rs == 32'd0);
    endtask

    // Linear sequence of directed steps followed by the parameter sweep.
    initial begin
        logic [31:0] va, vb, rs;
        logic        vs, vc, rc, ro, rz;
        int          lat8, lat32, lat1;
        logic [34:0] r8, r32, r1;

        rst   = 1'b1;
        start = 1'b1;
        sub   = 1'b0;
        a     = 32'h0000_1234;
        b     = 32'h0000_0001;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        expectResult("reset", 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("reset start ignored", {31'd0, busy}, 32'd0);

        runOp("add", 1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        runOp("carry chain", 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
        runOp("add ovf", 1'b0, 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        runOp("sub neg", 1'b1, 32'd5, 32'd7, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        runOp("sub ovf", 1'b1, 32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        runOp("sub borrow", 1'b1, 32'd9, 32'd4, 1'b1, 32'd4, 1'b1, 1'b0, 1'b0);

        // Start pulsed in RUN with different operands: ignored, not queued.
        applyStimulus(1'b0, 32'h10, 32'h20, 1'b0);
        @(negedge clk);
        start = 1'b1;
        sub   = 1'b1;
        cin   = 1'b1;
        a     = 32'hFFFF_0000;
        b     = 32'h0000_FFFF;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checkOutput("midrun busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        checkOutput("midrun done", {31'd0, done}, 32'd1);
        expectResult("midrun", 32'h30, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("midrun not queued", {31'd0, busy}, 32'd0);

        // Back-to-back: start held in DONE relaunches with no idle cycle.
        applyStimulus(1'b0, 32'd100, 32'd23, 1'b0);
        expectRun("b2b first");
        expectResult("b2b first", 32'd123, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h1000, 32'h1, 1'b0);
        expectRun("b2b second");
        expectResult("b2b second", 32'h0FFF, 1'b1, 1'b0, 1'b0);
        @(negedge clk);

        // Reset while idx is 2: aborts with no done and clears outputs.
        applyStimulus(1'b0, 32'd1, 32'd2, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        checkOutput("abort done", {31'd0, done}, 32'd0);
        expectResult("abort", 32'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("abort no done", {31'd0, done}, 32'd0);
        end
        runOp("after abort", 1'b0, 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0);

        // Sweep across DIGIT=8, 32 and 1 against the reference model.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            case (n)
                0:       begin va = 32'hFFFF_FFFF; vb = 32'h0;         vs = 1'b0; vc = 1'b1; end
                1:       begin va = 32'h7FFF_FFFF; vb = 32'h1;         vs = 1'b0; vc = 1'b0; end
                2:       begin va = 32'h8000_0000; vb = 32'h1;         vs = 1'b1; vc = 1'b0; end
                3:       begin va = 32'h1234_5678; vb = 32'h1234_5678; vs = 1'b1; vc = 1'b0; end
                default: begin va = $urandom; vb = $urandom; vs = 1'($urandom); vc = 1'($urandom); end
            endcase
            refModel(vs, va, vb, vc, rs, rc, ro, rz);
            applyStimulus(vs, va, vb, vc);
            lat8  = 0;
            lat32 = 0;
            lat1  = 0;
            r8    = '0;
            r32   = '0;
            r1    = '0;
            for (int cyc = 1; cyc <= 40; cyc++) begin
                @(negedge clk);
                if (done && lat8 == 0) begin
                    lat8 = cyc;
                    r8   = {ovf, zero, cout, s};
                end
                if (done32 && lat32 == 0) begin
                    lat32 = cyc;
                    r32   = {ovf32, zero32, cout32, s32};
                end
                if (done1 && lat1 == 0) begin
                    lat1 = cyc;
                    r1   = {ovf1, zero1, cout1, s1};
                end
            end
            checkOutput("sweep d8 latency", lat8, 32'd4);
            checkOutput("sweep d32 latency", lat32, 32'd1);
            checkOutput("sweep d1 latency", lat1, 32'd32);
            checkOutput("sweep d8 s", r8[31:0], rs);
            checkOutput("sweep d32 s", r32[31:0], rs);
            checkOutput("sweep d1 s", r1[31:0], rs);
            checkOutput("sweep d8 flags", {29'd0, r8[34:32]}, {29'd0, ro, rz, rc});
            checkOutput("sweep d32 flags", {29'd0, r32[34:32]}, {29'd0, ro, rz, rc});
            checkOutput("sweep d1 flags", {29'd0, r1[34:32]}, {29'd0, ro, rz, rc});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
